// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit path (arbiter and packetisers).
package gmii_tx_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, IFG} tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 8;

  localparam int FRAME_MIN_LEN    = 60;
  localparam int FRAME_MAX_LEN    = 1514;
  localparam int DEF_IFG_CYCLES   = 12;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/gmii_tx_arb_pick.sv
// Audio-first source pick with a starvation counter that forces a video grant
// after STARVE_LIMIT consecutive audio grants while video is waiting.
module gmii_tx_arb_pick
  import gmii_tx_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk125,
  input  logic sys_rst_n,
  input  logic vid_req_i,
  input  logic aud_req_i,
  input  logic grant_i,
  output logic pick_valid_o,
  output logic pick_aud_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign pick_valid_o = aud_req_i || vid_req_i;
  assign pick_aud_o   = aud_req_i && !(vid_req_i && (starve_q == SW'(STARVE_LIMIT)));

  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      if (pick_aud_o && vid_req_i) begin
        starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares the GMII TX port between video and audio frame FIFOs: arbitrates, adds
// preamble/SFD, streams len bytes (read 2 cycles ahead of txd), then holds the IFG.
module gmii_tx_arbiter
  import gmii_tx_pkg::*;
#(
  parameter int IFG_CYCLES   = DEF_IFG_CYCLES,
  parameter int MIN_LEN      = FRAME_MIN_LEN,
  parameter int MAX_LEN      = FRAME_MAX_LEN,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        vid_req,
  input  logic [10:0] vid_len,
  output logic        vid_rd,
  input  logic [7:0]  vid_data,
  output logic        vid_done,
  output logic        vid_drop,
  input  logic        aud_req,
  input  logic [10:0] aud_len,
  output logic        aud_rd,
  input  logic [7:0]  aud_data,
  output logic        aud_done,
  output logic        aud_drop,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        grant_aud
);

  localparam int IW = $clog2(IFG_CYCLES + 1);

  tx_state_e      state_q;
  logic [2:0]     pre_cnt_q;
  logic [10:0]    byte_cnt_q;
  logic [10:0]    len_q;
  logic [IW-1:0]  ifg_cnt_q;
  logic [7:0]     txd_q;
  logic           tx_en_q, rd_q, done_q, busy_q, grant_aud_q;
  logic           vid_drop_q, aud_drop_q;

  logic        pick_valid, pick_aud, arb_en, pick_ok, grant;
  logic [10:0] pick_len;
  logic [7:0]  src_data;

  gmii_tx_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk125       (clk125),
    .sys_rst_n    (sys_rst_n),
    .vid_req_i    (vid_req),
    .aud_req_i    (aud_req),
    .grant_i      (grant),
    .pick_valid_o (pick_valid),
    .pick_aud_o   (pick_aud)
  );

  // A source still shows req during its drop pulse; skip that cycle so it is not dropped twice.
  assign arb_en   = (state_q == IDLE) && pick_valid && !vid_drop_q && !aud_drop_q;
  assign pick_len = pick_aud ? aud_len : vid_len;
  assign pick_ok  = (pick_len >= 11'(MIN_LEN)) && (pick_len <= 11'(MAX_LEN));
  assign grant    = arb_en && pick_ok;
  assign src_data = grant_aud_q ? aud_data : vid_data;

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      ifg_cnt_q   <= '0;
      txd_q       <= '0;
      tx_en_q     <= 1'b0;
      rd_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      grant_aud_q <= 1'b0;
      vid_drop_q  <= 1'b0;
      aud_drop_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      vid_drop_q <= 1'b0;
      aud_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_en) begin
            if (pick_ok) begin
              state_q     <= PRE;
              len_q       <= pick_len;
              grant_aud_q <= pick_aud;
              pre_cnt_q   <= '0;
              tx_en_q     <= 1'b1;
              txd_q       <= PREAMBLE_BYTE;
              busy_q      <= 1'b1;
            end else begin
              vid_drop_q <= !pick_aud;
              aud_drop_q <= pick_aud;
            end
          end
        end
        PRE: begin
          pre_cnt_q <= pre_cnt_q + 3'd1;
          // First read two cycles before the SFD leaves so byte 0 lands right behind it.
          if (pre_cnt_q == 3'(PREAMBLE_LEN - 3)) begin
            rd_q <= 1'b1;
          end
          if (pre_cnt_q == 3'(PREAMBLE_LEN - 2)) begin
            txd_q <= SFD_BYTE;
          end else if (pre_cnt_q == 3'(PREAMBLE_LEN - 1)) begin
            txd_q      <= src_data;
            byte_cnt_q <= len_q;
            state_q    <= DATA;
          end else begin
            txd_q <= PREAMBLE_BYTE;
          end
        end
        DATA: begin
          if (byte_cnt_q == 11'd1) begin
            state_q    <= IFG;
            tx_en_q    <= 1'b0;
            txd_q      <= '0;
            rd_q       <= 1'b0;
            byte_cnt_q <= '0;
            ifg_cnt_q  <= IW'(IFG_CYCLES);
          end else begin
            txd_q      <= src_data;
            byte_cnt_q <= byte_cnt_q - 11'd1;
            done_q     <= (byte_cnt_q == 11'd2);
            rd_q       <= (byte_cnt_q >= 11'd4);
          end
        end
        IFG: begin
          if (ifg_cnt_q == IW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ifg_cnt_q <= ifg_cnt_q - IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd       = txd_q;
  assign tx_en     = tx_en_q;
  assign busy      = busy_q;
  assign grant_aud = grant_aud_q;
  assign vid_rd    = rd_q & ~grant_aud_q;
  assign aud_rd    = rd_q & grant_aud_q;
  assign vid_done  = done_q & ~grant_aud_q;
  assign aud_done  = done_q & grant_aud_q;
  assign vid_drop  = vid_drop_q;
  assign aud_drop  = aud_drop_q;

endmodule
